// File: rtl/bsg_downstream_pkg.sv
// Shared types and default sizing for the downstream gearbox (state encoding, width helpers).
package bsg_downstream_pkg;

  typedef enum logic {
    COLLECT = 1'b0,
    HOLD    = 1'b1
  } state_e;

  localparam int DEF_IO_W        = 8;
  localparam int DEF_BEATS       = 4;
  localparam int DEF_DEPTH       = 32;
  localparam int DEF_TOKEN_BATCH = 4;

  // Pointer width carries one extra wrap bit so full and empty are distinguishable.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int cnt_w(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

  function automatic int tok_w(input int batch);
    return $clog2(batch + 1);
  endfunction

endpackage

// File: rtl/bsg_downstream_buffer.sv
// Circular beat buffer with wrap-bit pointers, occupancy count and sticky overflow flag.
module bsg_downstream_buffer
  import bsg_downstream_pkg::*;
#(
  parameter int IO_W  = DEF_IO_W,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_valid,
  input  logic [IO_W-1:0]        push_data,
  input  logic                   pop,
  output logic [IO_W-1:0]        pop_data,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] occupancy,
  output logic                   overflow
);

  localparam int PTR_W = ptr_w(DEPTH);
  localparam int AW    = $clog2(DEPTH);

  logic [IO_W-1:0]  mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic             overflow_q, overflow_d;
  logic             full;
  logic             push;

  assign occupancy = wptr_q - rptr_q;
  assign empty     = (wptr_q == rptr_q);
  assign full      = (occupancy == PTR_W'(DEPTH));
  assign pop_data  = mem_q[rptr_q[AW-1:0]];
  assign overflow  = overflow_q;

  // Full is taken from registered state, so a same-cycle pop never makes room for a write.
  always_comb begin
    push       = push_valid && !full;
    wptr_d     = wptr_q + PTR_W'(push);
    rptr_d     = rptr_q + PTR_W'(pop);
    overflow_d = overflow_q | (push_valid & full);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bsg_downstream_gearbox.sv
// Downstream gearbox: buffers IO beats, packs BEATS of them per core word, returns credit tokens.
// Build option BSG_DOWNSTREAM_MSB_FIRST_EN places the first beat of a word in the top slot.
module bsg_downstream_gearbox
  import bsg_downstream_pkg::*;
#(
  parameter int IO_W        = DEF_IO_W,
  parameter int BEATS       = DEF_BEATS,
  parameter int DEPTH       = DEF_DEPTH,
  parameter int TOKEN_BATCH = DEF_TOKEN_BATCH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    io_valid_in,
  input  logic [IO_W-1:0]         io_data_in,
  output logic                    io_token_out,
  output logic                    core_valid_out,
  output logic [IO_W*BEATS-1:0]   core_data_out,
  input  logic                    core_ready,
  output logic [$clog2(DEPTH):0]  occupancy,
  output logic                    overflow
);

  localparam int CORE_W = IO_W * BEATS;
  localparam int CNT_W  = cnt_w(BEATS);
  localparam int TOK_W  = tok_w(TOKEN_BATCH);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  beat_cnt_q, beat_cnt_d;
  logic [TOK_W-1:0]  tok_cnt_q, tok_cnt_d;
  logic              token_q, token_d;
  logic              valid_q, valid_d;
  logic [CORE_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  slot;
  logic              accept;
  logic              pop;
  logic              empty;
  logic [IO_W-1:0]   pop_data;

  bsg_downstream_buffer #(
    .IO_W  (IO_W),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_valid (io_valid_in),
    .push_data  (io_data_in),
    .pop        (pop),
    .pop_data   (pop_data),
    .empty      (empty),
    .occupancy  (occupancy),
    .overflow   (overflow)
  );

`ifdef BSG_DOWNSTREAM_MSB_FIRST_EN
  assign slot = CNT_W'(BEATS - 1) - beat_cnt_q;
`else
  assign slot = beat_cnt_q;
`endif

  // A word handoff and the first pop of the next word share one cycle, so there is no bubble.
  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    tok_cnt_d  = tok_cnt_q;
    token_d    = 1'b0;
    valid_d    = valid_q;
    word_d     = word_q;
    accept     = (state_q == HOLD) && core_ready;
    pop        = !empty && ((state_q == COLLECT) || accept);

    if (accept) begin
      valid_d = 1'b0;
      state_d = COLLECT;
    end

    if (pop) begin
      word_d[int'(slot)*IO_W +: IO_W] = pop_data;
      if (beat_cnt_q == CNT_W'(BEATS - 1)) begin
        beat_cnt_d = '0;
        valid_d    = 1'b1;
        state_d    = HOLD;
      end else begin
        beat_cnt_d = beat_cnt_q + CNT_W'(1);
      end

      if (tok_cnt_q == TOK_W'(TOKEN_BATCH - 1)) begin
        tok_cnt_d = '0;
        token_d   = 1'b1;
      end else begin
        tok_cnt_d = tok_cnt_q + TOK_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= COLLECT;
      beat_cnt_q <= '0;
      tok_cnt_q  <= '0;
      token_q    <= 1'b0;
      valid_q    <= 1'b0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      tok_cnt_q  <= tok_cnt_d;
      token_q    <= token_d;
      valid_q    <= valid_d;
      word_q     <= word_d;
    end
  end

  assign io_token_out   = token_q;
  assign core_valid_out = valid_q;
  assign core_data_out  = word_q;

endmodule

// File: tb/tb_bsg_downstream_gearbox.sv
// Scoreboard bench for bsg_downstream_gearbox: queue-based reference model plus output monitor.
module tb_bsg_downstream_gearbox;

  localparam int IO_W   = 8;
  localparam int BEATS  = 4;
  localparam int DEPTH  = 32;
  localparam int TBATCH = 4;
  localparam int CORE_W = IO_W * BEATS;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              io_valid_in = 1'b0;
  logic [IO_W-1:0]   io_data_in = '0;
  logic              io_token_out;
  logic              core_valid_out;
  logic [CORE_W-1:0] core_data_out;
  logic              core_ready = 1'b0;
  logic [5:0]        occupancy;
  logic              overflow;

  bsg_downstream_gearbox #(
    .IO_W        (IO_W),
    .BEATS       (BEATS),
    .DEPTH       (DEPTH),
    .TOKEN_BATCH (TBATCH)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .io_valid_in    (io_valid_in),
    .io_data_in     (io_data_in),
    .io_token_out   (io_token_out),
    .core_valid_out (core_valid_out),
    .core_data_out  (core_data_out),
    .core_ready     (core_ready),
    .occupancy      (occupancy),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int words_seen = 0;
  int tokens_seen = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: beats sit in a queue, a word is formed from BEATS popped beats.
  logic [IO_W-1:0]   fifo_m[$];
  logic [IO_W-1:0]   cur_m[$];
  logic [CORE_W-1:0] exp_q[$];
  bit                hold_m = 0;
  bit                tokp_m = 0;
  bit                ovf_m = 0;
  int                tok_m = 0;

  function automatic logic [CORE_W-1:0] build_word();
    logic [CORE_W-1:0] w = '0;
    for (int i = 0; i < BEATS; i++) begin
`ifdef BSG_DOWNSTREAM_MSB_FIRST_EN
      w[(BEATS-1-i)*IO_W +: IO_W] = cur_m[i];
`else
      w[i*IO_W +: IO_W] = cur_m[i];
`endif
    end
    return w;
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    bit can_pop;
    bit can_push;
    if (!rst_n) begin
      fifo_m.delete();
      cur_m.delete();
      exp_q.delete();
      hold_m = 0;
      tokp_m = 0;
      ovf_m  = 0;
      tok_m  = 0;
    end else begin
      tokp_m   = 0;
      can_pop  = (fifo_m.size() > 0) && (!hold_m || core_ready);
      can_push = io_valid_in && (fifo_m.size() < DEPTH);
      if (io_valid_in && !can_push) ovf_m = 1;
      if (hold_m && core_ready) hold_m = 0;
      if (can_pop) begin
        cur_m.push_back(fifo_m.pop_front());
        tok_m++;
        if (tok_m == TBATCH) begin
          tok_m  = 0;
          tokp_m = 1;
        end
        if (cur_m.size() == BEATS) begin
          exp_q.push_back(build_word());
          cur_m.delete();
          hold_m = 1;
        end
      end
      if (can_push) fifo_m.push_back(io_data_in);
    end
  end

  // Monitor: compares DUT state against the model away from the active edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      chk("rst_valid", 32'(core_valid_out), 32'd0);
      chk("rst_data", core_data_out, 32'd0);
      chk("rst_token", 32'(io_token_out), 32'd0);
      chk("rst_occupancy", 32'(occupancy), 32'd0);
      chk("rst_overflow", 32'(overflow), 32'd0);
    end else begin
      chk("occupancy", 32'(occupancy), 32'(fifo_m.size()));
      chk("valid", 32'(core_valid_out), 32'(hold_m));
      chk("token", 32'(io_token_out), 32'(tokp_m));
      chk("overflow", 32'(overflow), 32'(ovf_m));
      if (io_token_out) tokens_seen++;
      if (core_valid_out && core_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL word: unexpected word 0x%0h at %0t", core_data_out, $time);
        end else begin
          chk("word", core_data_out, exp_q.pop_front());
          words_seen++;
        end
      end
    end
  end

  task automatic step(input bit v, input logic [IO_W-1:0] d, input bit r);
    io_valid_in = v;
    io_data_in  = d;
    core_ready  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(0, '0, 0);
    step(0, '0, 0);
    rst_n = 1'b1;
  endtask

  // Four beats on consecutive cycles; the word must appear exactly two cycles after the last beat.
  task automatic directed_word(input logic [31:0] beats, input logic [31:0] exp);
    for (int i = 0; i < BEATS; i++) step(1, beats[i*IO_W +: IO_W], 1);
    io_valid_in = 1'b0;
    @(negedge clk);
    chk("lat_early_valid", 32'(core_valid_out), 32'd0);
    @(posedge clk);
    @(negedge clk);
    chk("lat_valid", 32'(core_valid_out), 32'd1);
    chk("lat_data", core_data_out, exp);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int w0, t0;
    bit drained;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;

`ifdef BSG_DOWNSTREAM_MSB_FIRST_EN
    directed_word(32'h44332211, 32'h11223344);
`else
    directed_word(32'h44332211, 32'h44332211);
`endif
    repeat (3) step(0, '0, 1);

    // Fill with the core stalled, then overflow and a pop racing a write into a full buffer.
    for (int i = 0; i < 40; i++) step(1, IO_W'(8'h80 + i), 0);
    @(negedge clk);
    chk("fill_occupancy", 32'(occupancy), 32'(DEPTH));
    chk("fill_overflow", 32'(overflow), 32'd1);
    step(1, 8'hEE, 1);
    @(negedge clk);
    chk("full_pop_occupancy", 32'(occupancy), 32'(DEPTH - 1));
    repeat (40) step(0, '0, 1);

    do_reset();
    @(negedge clk);
    chk("post_rst_overflow", 32'(overflow), 32'd0);

    // Reset in the middle of a word: two beats popped, then discarded.
    step(1, 8'hA1, 1);
    step(1, 8'hA2, 1);
    step(0, '0, 1);
    step(0, '0, 1);
    do_reset();
`ifdef BSG_DOWNSTREAM_MSB_FIRST_EN
    directed_word(32'hD4C3B2A1, 32'hA1B2C3D4);
`else
    directed_word(32'hD4C3B2A1, 32'hD4C3B2A1);
`endif
    step(0, '0, 1);

    // 100 back-to-back words crossing the pointer wrap many times.
    w0 = words_seen;
    t0 = tokens_seen;
    for (int i = 0; i < 100 * BEATS; i++) step(1, IO_W'($urandom), 1);
    repeat (4) step(0, '0, 1);
    chk("stream_words", 32'(words_seen - w0), 32'd100);
    chk("stream_tokens", 32'(tokens_seen - t0), 32'd100);
    chk("stream_overflow", 32'(overflow), 32'd0);

    // Random traffic and back-pressure, including overflow episodes.
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 3) != 0, IO_W'($urandom), $urandom_range(0, 2) != 0);

    drained = 0;
    for (int i = 0; i < 200 && !drained; i++) begin
      step(0, '0, 1);
      drained = (fifo_m.size() == 0) && !hold_m;
    end
    checks++;
    if (!drained) begin
      errors++;
      $display("FAIL drain: occupancy %0d still buffered, required 0", occupancy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded, required completion earlier", $time);
    $fatal(1, "watchdog");
  end

endmodule
